// File: rtl/spi_wb_bridge_pkg.sv
// Shared types and constants for the SPI-to-Wishbone bridge.
package spi_wb_bridge_pkg;

    // SPI frame sequencer: one state per byte of the CMD/ADDR/DATA frame.
    typedef enum logic [2:0] {
        SPI_IDLE  = 3'd0,
        SPI_CMD   = 3'd1,
        SPI_ADDR  = 3'd2,
        SPI_DATA  = 3'd3,
        SPI_DRAIN = 3'd4
    } spi_state_t;

    // Wishbone master: either idle or holding cyc/stb for one transfer.
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_BUSY = 1'b1
    } wb_state_t;

    // Bit of the command byte that selects write (1) or read (0).
    localparam int CMD_WRITE_BIT = 7;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchroniser for one SPI pin plus edge detection on the
// synchronised level. RST_VAL is the idle level of the pin.
module spi_slave_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronise the pin and keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            prev_r <= RST_VAL;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign dout = sync_r;
    assign rise = sync_r & ~prev_r;
    assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave that turns CMD/ADDR/DATA frames into single Wishbone
// byte reads and writes. Everything runs on wb_clk; SPI pins are
// oversampled through synchronisers.
module spi_wb_bridge
    import spi_wb_bridge_pkg::*;
#(
    parameter logic [23:0] ADDR_HI = 24'h000000,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        i_spi_sclk,
    input  logic        i_spi_cs_n,
    input  logic        i_spi_mosi,
    output logic        o_spi_miso,
    output logic [31:0] wb_m2s_adr,
    output logic [31:0] wb_m2s_dat,
    output logic [3:0]  wb_m2s_sel,
    output logic        wb_m2s_we,
    output logic        wb_m2s_cyc,
    output logic        wb_m2s_stb,
    input  logic [31:0] wb_s2m_dat,
    input  logic        wb_s2m_ack,
    input  logic        wb_s2m_err,
    output logic        o_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic cs_n_s, cs_fall_s, cs_rise_unused_s;
    logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;
    logic [23:0] rd_hi_unused_s;

    spi_wb_bridge_pkg::spi_state_t spi_state_r;
    spi_wb_bridge_pkg::wb_state_t  wb_state_r;
    logic [2:0]       bit_cnt_r;
    logic [6:0]       rx_r;
    logic [6:0]       tx_r;
    logic [7:0]       addr_r;
    logic [7:0]       wdata_r;
    logic             is_write_r;
    logic             rd_pend_r;
    logic             wr_pend_r;
    logic             rd_wait_r;
    logic             cur_rd_r;
    logic [TMR_W-1:0] tmr_r;

    logic [7:0] rx_byte_s;
    logic       spi_active_s;
    logic       wb_busy_s;
    logic       wb_accept_s;
    logic       wb_done_s;
    logic       wb_fault_s;
    logic       late_s;
    logic       late_data_s;
    logic       rd_ack_s;

    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(wb_clk), .rst(wb_rst), .din(i_spi_sclk),
        .dout(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_slave_sync #(.RST_VAL(1'b1)) u_sync_cs_n (
        .clk(wb_clk), .rst(wb_rst), .din(i_spi_cs_n),
        .dout(cs_n_s), .rise(cs_rise_unused_s), .fall(cs_fall_s)
    );
    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(wb_clk), .rst(wb_rst), .din(i_spi_mosi),
        .dout(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
    );

    assign rd_hi_unused_s = wb_s2m_dat[31:8];
    assign rx_byte_s      = {rx_r, mosi_s};
    assign spi_active_s   = ~cs_n_s & (spi_state_r != SPI_IDLE) & sclk_s;
    assign wb_busy_s      = (wb_state_r == WB_BUSY);
    // A frame that has been deselected may not start a new transfer.
    assign wb_accept_s    = (wb_state_r == WB_IDLE) & (rd_pend_r | wr_pend_r) & ~cs_n_s;
    assign wb_done_s      = wb_busy_s & (wb_s2m_ack | wb_s2m_err | (tmr_r == TMR_LAST));
    assign wb_fault_s     = wb_busy_s & ~wb_s2m_ack & (wb_s2m_err | (tmr_r == TMR_LAST));
    // First DATA edge reached with read data still outstanding.
    assign late_s         = sclk_rise_s & spi_active_s & (spi_state_r == SPI_DATA)
                          & ~is_write_r & (bit_cnt_r == 3'd0) & rd_wait_r;
    assign late_data_s    = wb_busy_s & wb_s2m_ack & cur_rd_r & ~rd_wait_r;
    assign rd_ack_s       = wb_busy_s & wb_s2m_ack & cur_rd_r & rd_wait_r & ~late_s;

    // SPI frame sequencer: shift in bytes, queue WB requests, drive MISO.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            spi_state_r <= SPI_IDLE;
            bit_cnt_r   <= 3'd0;
            rx_r        <= 7'd0;
            tx_r        <= 7'd0;
            addr_r      <= 8'd0;
            wdata_r     <= 8'd0;
            is_write_r  <= 1'b0;
            rd_pend_r   <= 1'b0;
            wr_pend_r   <= 1'b0;
            rd_wait_r   <= 1'b0;
            o_spi_miso  <= 1'b0;
        end else if (cs_fall_s) begin
            spi_state_r <= SPI_CMD;
            bit_cnt_r   <= 3'd0;
            rx_r        <= 7'd0;
            tx_r        <= 7'd0;
            is_write_r  <= 1'b0;
            rd_pend_r   <= 1'b0;
            wr_pend_r   <= 1'b0;
            rd_wait_r   <= 1'b0;
            o_spi_miso  <= 1'b0;
        end else if (cs_n_s) begin
            spi_state_r <= SPI_IDLE;
            bit_cnt_r   <= 3'd0;
            rd_pend_r   <= 1'b0;
            wr_pend_r   <= 1'b0;
            rd_wait_r   <= 1'b0;
            o_spi_miso  <= 1'b0;
        end else begin
            if (wb_accept_s) begin
                rd_pend_r <= 1'b0;
                wr_pend_r <= 1'b0;
            end
            if (rd_ack_s) begin
                tx_r       <= wb_s2m_dat[6:0];
                o_spi_miso <= wb_s2m_dat[7];
                rd_wait_r  <= 1'b0;
            end
            if (late_s) begin
                rd_wait_r <= 1'b0;
            end
            if (sclk_rise_s && spi_active_s) begin
                rx_r      <= rx_byte_s[6:0];
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    case (spi_state_r)
                        SPI_CMD: begin
                            is_write_r  <= rx_byte_s[CMD_WRITE_BIT];
                            spi_state_r <= SPI_ADDR;
                        end
                        SPI_ADDR: begin
                            addr_r      <= rx_byte_s;
                            spi_state_r <= SPI_DATA;
                            if (!is_write_r) begin
                                // Preload all-ones so a missing ack reads back 0xFF.
                                rd_pend_r  <= 1'b1;
                                rd_wait_r  <= 1'b1;
                                tx_r       <= 7'h7F;
                                o_spi_miso <= 1'b1;
                            end
                        end
                        SPI_DATA: begin
                            spi_state_r <= SPI_DRAIN;
                            o_spi_miso  <= 1'b0;
                            if (is_write_r) begin
                                wdata_r   <= rx_byte_s;
                                wr_pend_r <= 1'b1;
                            end
                        end
                        SPI_DRAIN: spi_state_r <= SPI_DRAIN;
                        default:   spi_state_r <= SPI_IDLE;
                    endcase
                end
            end else if (sclk_fall_s && (spi_state_r == SPI_DATA) && !is_write_r
                         && (bit_cnt_r != 3'd0)) begin
                // Bit 7 is already on the pin; shift out the rest on falling edges.
                o_spi_miso <= tx_r[6];
                tx_r       <= {tx_r[5:0], 1'b0};
            end
        end
    end

    // Wishbone master: one transfer per queued request, with timeout.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wb_state_r <= WB_IDLE;
            wb_m2s_cyc <= 1'b0;
            wb_m2s_stb <= 1'b0;
            wb_m2s_we  <= 1'b0;
            wb_m2s_adr <= 32'd0;
            wb_m2s_dat <= 32'd0;
            wb_m2s_sel <= 4'd0;
            tmr_r      <= '0;
            cur_rd_r   <= 1'b0;
        end else begin
            case (wb_state_r)
                WB_IDLE: begin
                    if (wb_accept_s) begin
                        wb_state_r <= WB_BUSY;
                        wb_m2s_cyc <= 1'b1;
                        wb_m2s_stb <= 1'b1;
                        wb_m2s_adr <= {ADDR_HI, addr_r};
                        wb_m2s_sel <= 4'b0001;
                        tmr_r      <= '0;
                        if (wr_pend_r) begin
                            wb_m2s_we  <= 1'b1;
                            wb_m2s_dat <= {24'h000000, wdata_r};
                            cur_rd_r   <= 1'b0;
                        end else begin
                            wb_m2s_we  <= 1'b0;
                            cur_rd_r   <= 1'b1;
                        end
                    end
                end
                WB_BUSY: begin
                    if (wb_done_s) begin
                        wb_state_r <= WB_IDLE;
                        wb_m2s_cyc <= 1'b0;
                        wb_m2s_stb <= 1'b0;
                        cur_rd_r   <= 1'b0;
                    end else begin
                        tmr_r <= tmr_r + 1'b1;
                    end
                end
                default: begin
                    wb_state_r <= WB_IDLE;
                    wb_m2s_cyc <= 1'b0;
                    wb_m2s_stb <= 1'b0;
                end
            endcase
            // Read data for a deselected frame is no longer wanted.
            if (cs_n_s) begin
                cur_rd_r <= 1'b0;
            end
        end
    end

    // Sticky error flag, cleared when the next frame starts.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            o_err <= 1'b0;
        end else if (wb_fault_s || late_s || late_data_s) begin
            o_err <= 1'b1;
        end else if (cs_fall_s) begin
            o_err <= 1'b0;
        end
    end

endmodule
